r_alu: RTL and testbench
========================

// Module: r_alu
// PURPOSE
//  LEGv8 R-format ALU-instruction decoder for the control unit. Decodes a 32-bit
//  instruction word (ADD/SUB/ADDS/SUBS/AND/ORR/EOR/ANDS/LSR/LSL) into the 94-bit
//  datapath control word CW. The control word is registered, so the datapath
//  sees it one clock after the instruction is presented.
// PARAMETERS
//  none (all widths are fixed by the LEGv8 datapath)
// PORTS
//  clock   in   1   system clock, rising edge
//  reset   in   1   asynchronous, active-low reset (0 = reset)
//  i       in   32  instruction word: opcode[31:21] Rm[20:16] shamt[15:10] Rn[9:5] Rd[4:0]
//  CW      out  94  registered control word (packing below)
// BEHAVIOUR
//  - Internal registered fields, hierarchically visible under these exact names:
//    DA[4:0] SA[4:0] SB[4:0] FS[4:0] PS[1:0] enable[1:0] regWrite memWrite
//    PC_sel B_sel status_load k[63:0] state.
//  - CW = {state, k, status_load, B_sel, PC_sel, memWrite, regWrite, enable, PS, FS, SB, SA, DA}
//    DA=[4:0] SA=[9:5] SB=[14:10] FS=[19:15] PS=[21:20] enable=[23:22] regWrite=[24]
//    memWrite=[25] PC_sel=[26] B_sel=[27] status_load=[28] k=[92:29] state=[93].
//  - Reset (reset==0, async): every field and CW = 0 (PS=00 holds PC; no writes).
//  - Latency: each rising clock with reset==1 loads fields decoded from current i; 1 cycle.
//  - Common decode for a recognised opcode: DA=i[4:0], SA=i[9:5], SB=i[20:16],
//    k={58'b0, i[15:10]}, PS=01 (PC+4), enable=00 (ALU drives data bus), regWrite=1,
//    memWrite=0, PC_sel=0, state=0.
//  - FS encoding: FS[4:2] op (000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR),
//    FS[1] invert B, FS[0] carry-in.
//  - Opcode table (i[31:21] -> FS, B_sel, status_load):
//    10001011000 ADD  -> 01000,0,0 | 11001011000 SUB  -> 01011,0,0
//    10101011000 ADDS -> 01000,0,1 | 11101011000 SUBS -> 01011,0,1
//    10001010000 AND  -> 00000,0,0 | 10101010000 ORR  -> 00100,0,0
//    11001010000 EOR  -> 01100,0,0 | 11101010000 ANDS -> 00000,0,1
//    11010011010 LSR  -> 10100,1,0 | 11010011011 LSL  -> 10000,1,0
//  - B_sel=1 (shifts): ALU B operand is k (shamt); SB still equals i[20:16].
//  - Any other opcode (including i=0): NOP word -- regWrite=0, memWrite=0,
//    status_load=0, PS=01, FS=00000, B_sel=0, PC_sel=0, enable=00, state=0,
//    DA/SA/SB/k still taken from the instruction fields.
//  - Reset asserted mid-stream clears CW immediately; first edge after release
//    decodes the instruction then on i.
//  - No combinational path from i to CW.
// TESTING
//  1. reset=0 then any i -> CW==94'b0 without a clock edge.
//  2. i=10001011000_00001_000000_10000_00100 (ADD), 1 edge -> DA=4 SA=16 SB=1 FS=01000
//     PS=01 regWrite=1 status_load=0 B_sel=0 k=0 memWrite=0 state=0.
//  3. i=11001011000_00011_..., ADDS 10101011000_00111_..., SUBS 11101011000_01111_...
//     -> FS 01011/01000/01011, status_load 0/1/1, SB 3/7/15, DA=4 SA=16.
//  4. LSR 11010011010_00001_000010_10000_00100 -> FS=10100 B_sel=1 k=2;
//     LSL 11010011011_00000_000010_10000_00100 -> FS=10000 B_sel=1 k=2 SB=0.
//  5. AND/ORR/EOR/ANDS -> FS 00000/00100/01100/00000, status_load only for ANDS.
//  6. i=32'b0 after ADD -> next edge regWrite=0 status_load=0 PS=01; CW[28:24] checked
//     equal to fields; CW only changes on clock edges.

Source files
------------

// File: rtl/r_alu.sv
// r_alu: LEGv8 R-format ALU-instruction decoder.
// Turns a 32-bit instruction word into the 94-bit datapath control word.
// Every field is registered, so CW follows i by one clock and has no
// combinational path from i.
module r_alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i,
  output logic [93:0] CW
);

  // Opcodes i[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;

  // FS: [4:2] operation, [1] invert B, [0] carry-in
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01011;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // Registered control fields; the names are referenced hierarchically.
  logic [4:0]  DA, SA, SB, FS;
  logic [1:0]  PS, enable;
  logic        regWrite, memWrite, PC_sel, B_sel, status_load;
  logic [63:0] k;
  logic        state;

  logic [4:0]  DA_d, SA_d, SB_d, FS_d;
  logic [1:0]  PS_d, enable_d;
  logic        regWrite_d, memWrite_d, PC_sel_d, B_sel_d, status_load_d;
  logic [63:0] k_d;
  logic        state_d;

  // Decode the instruction; unrecognised opcodes fall through as a NOP word
  // that still carries the register and shamt fields.
  always_comb begin
    DA_d          = i[4:0];
    SA_d          = i[9:5];
    SB_d          = i[20:16];
    k_d           = {58'b0, i[15:10]};
    PS_d          = 2'b01;
    enable_d      = 2'b00;
    regWrite_d    = 1'b0;
    memWrite_d    = 1'b0;
    PC_sel_d      = 1'b0;
    B_sel_d       = 1'b0;
    status_load_d = 1'b0;
    FS_d          = FS_AND;
    state_d       = 1'b0;
    case (i[31:21])
      OP_ADD:  begin regWrite_d = 1'b1; FS_d = FS_ADD; end
      OP_SUB:  begin regWrite_d = 1'b1; FS_d = FS_SUB; end
      OP_ADDS: begin regWrite_d = 1'b1; FS_d = FS_ADD; status_load_d = 1'b1; end
      OP_SUBS: begin regWrite_d = 1'b1; FS_d = FS_SUB; status_load_d = 1'b1; end
      OP_AND:  begin regWrite_d = 1'b1; FS_d = FS_AND; end
      OP_ORR:  begin regWrite_d = 1'b1; FS_d = FS_OR;  end
      OP_EOR:  begin regWrite_d = 1'b1; FS_d = FS_XOR; end
      OP_ANDS: begin regWrite_d = 1'b1; FS_d = FS_AND; status_load_d = 1'b1; end
      // Shifts take the shift amount from k, so B comes from the constant path.
      OP_LSR:  begin regWrite_d = 1'b1; FS_d = FS_LSR; B_sel_d = 1'b1; end
      OP_LSL:  begin regWrite_d = 1'b1; FS_d = FS_LSL; B_sel_d = 1'b1; end
      default: ;
    endcase
  end

  // Register the control word; reset yields an all-zero word (PC held, no writes).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      DA          <= '0;
      SA          <= '0;
      SB          <= '0;
      FS          <= '0;
      PS          <= '0;
      enable      <= '0;
      regWrite    <= 1'b0;
      memWrite    <= 1'b0;
      PC_sel      <= 1'b0;
      B_sel       <= 1'b0;
      status_load <= 1'b0;
      k           <= '0;
      state       <= 1'b0;
    end else begin
      DA          <= DA_d;
      SA          <= SA_d;
      SB          <= SB_d;
      FS          <= FS_d;
      PS          <= PS_d;
      enable      <= enable_d;
      regWrite    <= regWrite_d;
      memWrite    <= memWrite_d;
      PC_sel      <= PC_sel_d;
      B_sel       <= B_sel_d;
      status_load <= status_load_d;
      k           <= k_d;
      state       <= state_d;
    end
  end

  assign CW = {state, k, status_load, B_sel, PC_sel, memWrite, regWrite,
               enable, PS, FS, SB, SA, DA};

endmodule

// File: tb/tb_r_alu.sv
// tb_r_alu: scoreboard bench for the r_alu control-word decoder.
module tb_r_alu;

  logic        clock;
  logic        reset;
  logic [31:0] i;
  logic [93:0] CW;

  int total = 0;
  int bad   = 0;

  logic [93:0] sbq[$];

  r_alu dut (
    .clock (clock),
    .reset (reset),
    .i     (i),
    .CW    (CW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected control word built from the documented packing.
  function automatic logic [93:0] exp_word(input logic [31:0] ins, input logic [4:0] fs,
                                           input logic bsel, input logic sl, input logic rw);
    return {1'b0, {58'b0, ins[15:10]}, sl, bsel, 1'b0, 1'b0, rw,
            2'b00, 2'b01, fs, ins[20:16], ins[9:5], ins[4:0]};
  endfunction

  // Present one instruction, record its expected word, step past the edge.
  task automatic drive(input logic [31:0] ins, input logic [4:0] fs,
                       input logic bsel, input logic sl, input logic rw);
    @(negedge clock);
    i = ins;
    sbq.push_back(exp_word(ins, fs, bsel, sl, rw));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [93:0] e;
    reset = 1'b1;
    i = 32'hFFFF_FFFF;
    #2 reset = 1'b0;
    #1;
    total++;
    if (CW !== 94'b0) begin bad++; $display("FAIL reset_async got=%h want=0", CW); end
    @(posedge clock); #1;
    total++;
    if (CW !== 94'b0) begin bad++; $display("FAIL reset_hold got=%h want=0", CW); end
    @(negedge clock);
    reset = 1'b1;
    drive(32'b10001011000_00001_000000_10000_00100, 5'b01000, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL reset_release got=%h want=%h", CW, e); end
  endtask

  task automatic test_add;
    logic [93:0] e;
    drive(32'b10001011000_00001_000000_10000_00100, 5'b01000, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL add_cw got=%h want=%h", CW, e); end
    total++;
    if ({dut.DA, dut.SA, dut.SB} !== {5'd4, 5'd16, 5'd1})
      begin bad++; $display("FAIL add_regs got=%0d/%0d/%0d want=4/16/1", dut.DA, dut.SA, dut.SB); end
    total++;
    if ({dut.FS, dut.PS, dut.regWrite, dut.status_load, dut.B_sel} !== {5'b01000, 2'b01, 1'b1, 1'b0, 1'b0})
      begin bad++; $display("FAIL add_ctl got=%b %b %b%b%b", dut.FS, dut.PS, dut.regWrite, dut.status_load, dut.B_sel); end
    total++;
    if ({dut.k, dut.memWrite, dut.state} !== 66'b0)
      begin bad++; $display("FAIL add_k got=%h %b%b want=0", dut.k, dut.memWrite, dut.state); end
  endtask

  task automatic test_arith_flags;
    logic [31:0] ins [3];
    logic [4:0]  fs  [3];
    logic        sl  [3];
    logic [4:0]  sb  [3];
    logic [93:0] e;
    ins[0] = 32'b11001011000_00011_000000_10000_00100; fs[0] = 5'b01011; sl[0] = 1'b0; sb[0] = 5'd3;
    ins[1] = 32'b10101011000_00111_000000_10000_00100; fs[1] = 5'b01000; sl[1] = 1'b1; sb[1] = 5'd7;
    ins[2] = 32'b11101011000_01111_000000_10000_00100; fs[2] = 5'b01011; sl[2] = 1'b1; sb[2] = 5'd15;
    for (int n = 0; n < 3; n++) begin
      drive(ins[n], fs[n], 1'b0, sl[n], 1'b1);
      e = sbq.pop_front();
      total++;
      if (CW !== e) begin bad++; $display("FAIL arith_cw[%0d] got=%h want=%h", n, CW, e); end
      total++;
      if ({CW[19:15], CW[28], CW[14:10]} !== {fs[n], sl[n], sb[n]})
        begin bad++; $display("FAIL arith_fields[%0d] got=%b %b %0d want=%b %b %0d", n, CW[19:15], CW[28], CW[14:10], fs[n], sl[n], sb[n]); end
    end
  endtask

  task automatic test_shifts;
    logic [93:0] e;
    drive(32'b11010011010_00001_000010_10000_00100, 5'b10100, 1'b1, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL lsr_cw got=%h want=%h", CW, e); end
    total++;
    if ({dut.FS, dut.B_sel, dut.k} !== {5'b10100, 1'b1, 64'd2})
      begin bad++; $display("FAIL lsr_fields got=%b %b %0d want=10100 1 2", dut.FS, dut.B_sel, dut.k); end
    drive(32'b11010011011_00000_000010_10000_00100, 5'b10000, 1'b1, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL lsl_cw got=%h want=%h", CW, e); end
    total++;
    if ({dut.FS, dut.B_sel, dut.k, dut.SB} !== {5'b10000, 1'b1, 64'd2, 5'd0})
      begin bad++; $display("FAIL lsl_fields got=%b %b %0d %0d want=10000 1 2 0", dut.FS, dut.B_sel, dut.k, dut.SB); end
  endtask

  task automatic test_logic;
    logic [10:0] op [4];
    logic [4:0]  fs [4];
    logic        sl [4];
    logic [31:0] ins;
    logic [93:0] e;
    op[0] = 11'b10001010000; fs[0] = 5'b00000; sl[0] = 1'b0;
    op[1] = 11'b10101010000; fs[1] = 5'b00100; sl[1] = 1'b0;
    op[2] = 11'b11001010000; fs[2] = 5'b01100; sl[2] = 1'b0;
    op[3] = 11'b11101010000; fs[3] = 5'b00000; sl[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ins = {op[n], 5'd9, 6'd5, 5'd17, 5'd30};
      drive(ins, fs[n], 1'b0, sl[n], 1'b1);
      e = sbq.pop_front();
      total++;
      if (CW !== e) begin bad++; $display("FAIL logic_cw[%0d] got=%h want=%h", n, CW, e); end
    end
  endtask

  task automatic test_nop;
    logic [93:0] e;
    logic [93:0] held;
    drive(32'b10001011000_00001_000000_10000_00100, 5'b01000, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL nop_pre got=%h want=%h", CW, e); end
    drive(32'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL nop_cw got=%h want=%h", CW, e); end
    total++;
    if ({CW[28:24], CW[21:20]} !== {5'b00000, 2'b01} ||
        CW[28:24] !== {dut.status_load, dut.B_sel, dut.PC_sel, dut.memWrite, dut.regWrite})
      begin bad++; $display("FAIL nop_flags got=%b ps=%b want=00000 01", CW[28:24], CW[21:20]); end
    // Instruction changes mid-cycle must not reach CW before the next edge.
    held = CW;
    @(negedge clock);
    i = 32'b11101011000_01111_000011_00010_00001;
    #2;
    total++;
    if (CW !== held) begin bad++; $display("FAIL no_comb_path got=%h want=%h", CW, held); end
    drive(32'b11111000010_10101_010101_01010_11111, 5'b00000, 1'b0, 1'b0, 1'b0);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL nop_other got=%h want=%h", CW, e); end
  endtask

  task automatic test_reset_mid;
    logic [93:0] e;
    drive(32'b10101011000_00111_000100_10000_00100, 5'b01000, 1'b0, 1'b1, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL mid_pre got=%h want=%h", CW, e); end
    #1 reset = 1'b0;
    #1;
    total++;
    if (CW !== 94'b0) begin bad++; $display("FAIL mid_reset got=%h want=0", CW); end
    @(negedge clock);
    reset = 1'b1;
    drive(32'b11001011000_00011_000000_10000_00100, 5'b01011, 1'b0, 1'b0, 1'b1);
    e = sbq.pop_front();
    total++;
    if (CW !== e) begin bad++; $display("FAIL mid_release got=%h want=%h", CW, e); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] op [11];
    logic [4:0]  fs [11];
    logic        bs [11];
    logic        sl [11];
    logic        rw [11];
    logic [31:0] ins;
    logic [93:0] e;
    int          idx;
    op[0]  = 11'b10001011000; fs[0]  = 5'b01000; bs[0]  = 0; sl[0]  = 0; rw[0]  = 1;
    op[1]  = 11'b11001011000; fs[1]  = 5'b01011; bs[1]  = 0; sl[1]  = 0; rw[1]  = 1;
    op[2]  = 11'b10101011000; fs[2]  = 5'b01000; bs[2]  = 0; sl[2]  = 1; rw[2]  = 1;
    op[3]  = 11'b11101011000; fs[3]  = 5'b01011; bs[3]  = 0; sl[3]  = 1; rw[3]  = 1;
    op[4]  = 11'b10001010000; fs[4]  = 5'b00000; bs[4]  = 0; sl[4]  = 0; rw[4]  = 1;
    op[5]  = 11'b10101010000; fs[5]  = 5'b00100; bs[5]  = 0; sl[5]  = 0; rw[5]  = 1;
    op[6]  = 11'b11001010000; fs[6]  = 5'b01100; bs[6]  = 0; sl[6]  = 0; rw[6]  = 1;
    op[7]  = 11'b11101010000; fs[7]  = 5'b00000; bs[7]  = 0; sl[7]  = 1; rw[7]  = 1;
    op[8]  = 11'b11010011010; fs[8]  = 5'b10100; bs[8]  = 1; sl[8]  = 0; rw[8]  = 1;
    op[9]  = 11'b11010011011; fs[9]  = 5'b10000; bs[9]  = 1; sl[9]  = 0; rw[9]  = 1;
    op[10] = 11'b11111000000; fs[10] = 5'b00000; bs[10] = 0; sl[10] = 0; rw[10] = 0;
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 10);
      ins = {op[idx], 21'($urandom)};
      drive(ins, fs[idx], bs[idx], sl[idx], rw[idx]);
      e = sbq.pop_front();
      total++;
      if (CW !== e) begin bad++; $display("FAIL b2b[%0d] op=%b got=%h want=%h", n, op[idx], CW, e); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_arith_flags;
    test_shifts;
    test_logic;
    test_nop;
    test_reset_mid;
    test_back_to_back;
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
